// File: rtl/score_accumulator_pkg.sv
// rtl/score_accumulator_pkg.sv - shared encodings and defaults for the score accumulator
package score_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    localparam logic [1:0] MOD_NORMAL = 2'b00;
    localparam logic [1:0] MOD_NOFAIL = 2'b01;
    localparam logic [1:0] MOD_HALF   = 2'b10;
    localparam logic [1:0] MOD_DOUBLE = 2'b11;

    localparam int W_DEF       = 16;
    localparam int HP_MAX_DEF  = 100;
    localparam int HP_LOSS_DEF = 10;
    localparam int HP_GAIN_DEF = 2;

    function automatic logic can_fail(input logic [1:0] mod_code);
        return mod_code != MOD_NOFAIL;
    endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - W-bit unsigned saturating adder, combinational
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign y    = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - per-note score/combo/health accumulation with song state FSM
module score_accumulator
    import score_accumulator_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int HP_MAX  = HP_MAX_DEF,
    parameter int HP_LOSS = HP_LOSS_DEF,
    parameter int HP_GAIN = HP_GAIN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] total_note,
    input  logic [1:0]   mod,
    input  logic         judge_valid,
    input  logic [W-1:0] base_score,
    input  logic [W-1:0] bonus_score,
    input  logic [W-1:0] combo,
    output logic [W-1:0] last_combo,
    output logic [W-1:0] last_base_score,
    output logic [W-1:0] now_cnt,
    output logic [W-1:0] total_score,
    output logic [W-1:0] max_combo,
    output logic [7:0]   health,
    output logic         playing,
    output logic         finished,
    output logic         failed
);

    localparam logic [7:0] HP_FULL = 8'(HP_MAX);
    localparam logic [7:0] HP_DROP = 8'(HP_LOSS);

    state_t       state, state_n;
    logic [W-1:0] total_note_q, total_note_n;
    logic [1:0]   mod_q, mod_n;
    logic [W-1:0] last_combo_n, last_base_n, now_cnt_n, total_score_n, max_combo_n;
    logic [7:0]   health_n;
    logic [W-1:0] base_sum, judge_sum, total_sum;
    logic [8:0]   hp_up;

    sat_add #(.W(W)) u_base_acc  (.a(last_base_score), .b(base_score),  .y(base_sum));
    sat_add #(.W(W)) u_judge_sum (.a(base_score),      .b(bonus_score), .y(judge_sum));
    sat_add #(.W(W)) u_total_acc (.a(total_score),     .b(judge_sum),   .y(total_sum));

    assign hp_up = {1'b0, health} + 9'(HP_GAIN);

    always_comb begin
        state_n       = state;
        total_note_n  = total_note_q;
        mod_n         = mod_q;
        last_combo_n  = last_combo;
        last_base_n   = last_base_score;
        now_cnt_n     = now_cnt;
        total_score_n = total_score;
        max_combo_n   = max_combo;
        health_n      = health;
        if (start) begin
            total_note_n  = total_note;
            mod_n         = mod;
            last_combo_n  = '0;
            last_base_n   = '0;
            now_cnt_n     = '0;
            total_score_n = '0;
            max_combo_n   = '0;
            health_n      = HP_FULL;
            state_n       = (total_note == '0) ? ST_DONE : ST_PLAY;
        end else if (state == ST_PLAY && judge_valid) begin
            now_cnt_n     = (now_cnt == {W{1'b1}}) ? now_cnt : now_cnt + W'(1);
            last_combo_n  = combo;
            max_combo_n   = (combo > max_combo) ? combo : max_combo;
            last_base_n   = base_sum;
            total_score_n = total_sum;
            if (base_score == '0)
                health_n = (health > HP_DROP) ? health - HP_DROP : 8'd0;
            else
                health_n = (hp_up >= {1'b0, HP_FULL}) ? HP_FULL : hp_up[7:0];
            // Exit decisions look at the values this same edge will store
            if (health_n == 8'd0 && can_fail(mod_q))
                state_n = ST_FAIL;
            else if (now_cnt_n == total_note_q)
                state_n = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            total_note_q    <= '0;
            mod_q           <= MOD_NORMAL;
            last_combo      <= '0;
            last_base_score <= '0;
            now_cnt         <= '0;
            total_score     <= '0;
            max_combo       <= '0;
            health          <= HP_FULL;
            playing         <= 1'b0;
            finished        <= 1'b0;
            failed          <= 1'b0;
        end else begin
            state           <= state_n;
            total_note_q    <= total_note_n;
            mod_q           <= mod_n;
            last_combo      <= last_combo_n;
            last_base_score <= last_base_n;
            now_cnt         <= now_cnt_n;
            total_score     <= total_score_n;
            max_combo       <= max_combo_n;
            health          <= health_n;
            playing         <= (state_n == ST_PLAY);
            finished        <= (state_n == ST_DONE);
            failed          <= (state_n == ST_FAIL);
        end
    end

endmodule
